// File: rtl/camera_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer.
//   - cfg_state_e  : sequencer states
//   - cfg_word_t   : one table entry {addr, data}
//   - cfg_rom_t    : full 256-entry table image
//   - CFG_*        : marker encodings and default timing constants
//   - cfg_default_rom() : production initialisation table
package camera_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_DELAY,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_word_t;

  localparam int CFG_DEPTH = 256;
  typedef logic [CFG_DEPTH-1:0][15:0] cfg_rom_t;

  // addr 0xFF marks a delay entry; {FF,FF} ends the table.
  localparam logic [7:0]  CFG_DELAY_ADDR = 8'hFF;
  localparam logic [15:0] CFG_END_WORD   = 16'hFFFF;

  localparam int CFG_CLK_PER_MS  = 25000;
  localparam int CFG_POWERUP_MS  = 10;
  localparam int CFG_TX_CYCLES   = 65536;
  localparam int CFG_ACK_TIMEOUT = 131072;
  localparam int CFG_MAX_ENTRIES = 256;

  // Production table: soft reset, 10 ms settle, sensor register list, end.
  function automatic cfg_rom_t cfg_default_rom();
    cfg_rom_t t;
    for (int i = 0; i < CFG_DEPTH; i++) t[i] = CFG_END_WORD;
    t[0]  = 16'h1280;  // COM7: soft reset
    t[1]  = 16'hFF0A;  // wait 10 ms for the sensor to come back
    t[2]  = 16'h1101;  // CLKRC: prescaler
    t[3]  = 16'h1204;  // COM7: RGB output
    t[4]  = 16'h0C04;  // COM3: scaling enable
    t[5]  = 16'h3E19;  // COM14: PCLK divider
    t[6]  = 16'h703A;  // SCALING_XSC
    t[7]  = 16'h7135;  // SCALING_YSC
    t[8]  = 16'h40D0;  // COM15: RGB565, full range
    t[9]  = 16'h8C00;  // RGB444 off
    t[10] = 16'h3A04;  // TSLB
    t[11] = CFG_END_WORD;
    return t;
  endfunction

endpackage

// File: rtl/camera_cfg_rom.sv
// Combinational table lookup for the configuration sequencer.
//   index : table index (8 bits)
//   word  : {addr, data} entry at that index
// ROM_FILE carries the table image itself, so the lookup elaborates into
// plain logic with no file needed at build time; instantiating designs
// substitute their own table through it.
module camera_cfg_rom
  import camera_cfg_pkg::*;
#(
  parameter cfg_rom_t ROM_FILE = cfg_default_rom()
) (
  input  logic [7:0]  index,
  output logic [15:0] word
);

  assign word = ROM_FILE[index];

endmodule

// File: rtl/camera_cfg_sequencer.sv
// Walks the camera init table and feeds it to the SCCB sender one write
// at a time, with power-up wait, table-driven delays, final drain and an
// ack timeout.
//   clk, reset         : clock, synchronous active-high reset
//   start              : rerun pulse, honoured only in DONE/ERROR
//   sccb_ok            : sender accept pulse
//   cfg_ok/reg_addr/value : write request to the sender (registered)
//   busy/done/err      : status levels (registered)
module camera_cfg_sequencer
  import camera_cfg_pkg::*;
#(
  parameter int       CLK_PER_MS  = CFG_CLK_PER_MS,
  parameter int       POWERUP_MS  = CFG_POWERUP_MS,
  parameter int       TX_CYCLES   = CFG_TX_CYCLES,
  parameter int       ACK_TIMEOUT = CFG_ACK_TIMEOUT,
  parameter int       MAX_ENTRIES = CFG_MAX_ENTRIES,
  parameter cfg_rom_t ROM_FILE    = cfg_default_rom()
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sccb_ok,
  output logic       cfg_ok,
  output logic [7:0] reg_addr,
  output logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [31:0] PWRUP_LAST   = 32'(POWERUP_MS * CLK_PER_MS - 1);
  localparam logic [31:0] DRAIN_LAST   = 32'(TX_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] CLK_MS       = 32'(CLK_PER_MS);
  localparam logic [7:0]  IDX_LAST     = 8'(MAX_ENTRIES - 1);

  cfg_state_e  state, state_n;
  logic [7:0]  idx, idx_n;
  logic [31:0] cnt, cnt_n;
  cfg_word_t   word_q, word_n;
  logic [15:0] rom_word;
  logic        cfg_ok_n;
  logic [7:0]  reg_addr_n, value_n;
  logic        adv;

  camera_cfg_rom #(.ROM_FILE(ROM_FILE)) u_rom (
    .index (idx),
    .word  (rom_word)
  );

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    word_n     = word_q;
    cfg_ok_n   = cfg_ok;
    reg_addr_n = reg_addr;
    value_n    = value;
    adv        = 1'b0;

    case (state)
      ST_PWRUP: begin
        if (cnt == PWRUP_LAST) begin
          state_n = ST_FETCH;
          idx_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      ST_FETCH: begin
        word_n  = rom_word;
        state_n = ST_DECODE;
      end
      ST_DECODE: begin
        if (word_q == CFG_END_WORD) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end else if (word_q.addr == CFG_DELAY_ADDR) begin
          // A zero delay skips DELAY entirely and just moves on.
          if (word_q.data == 8'd0) begin
            adv = 1'b1;
          end else begin
            state_n = ST_DELAY;
            cnt_n   = 32'(word_q.data) * CLK_MS;
          end
        end else begin
          reg_addr_n = word_q.addr;
          value_n    = word_q.data;
          cfg_ok_n   = 1'b1;
          cnt_n      = '0;
          state_n    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The ack wins over a timeout landing on the same cycle.
        if (sccb_ok) begin
          cfg_ok_n = 1'b0;
          adv      = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          cfg_ok_n = 1'b0;
          state_n  = ST_ERROR;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      ST_DELAY: begin
        if (cnt <= 32'd1) adv = 1'b1;
        else              cnt_n = cnt - 32'd1;
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) state_n = ST_DONE;
        else                   cnt_n   = cnt + 32'd1;
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = ST_FETCH;
        end
      end
      default: state_n = ST_PWRUP;
    endcase

    // Having handled the last table slot counts as end of table, so the
    // index never has to move past IDX_LAST.
    if (adv) begin
      if (idx == IDX_LAST) begin
        state_n = ST_DRAIN;
        cnt_n   = '0;
      end else begin
        idx_n   = idx + 8'd1;
        state_n = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PWRUP;
      idx      <= '0;
      cnt      <= '0;
      word_q   <= '0;
      cfg_ok   <= 1'b0;
      reg_addr <= '0;
      value    <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      word_q   <= word_n;
      cfg_ok   <= cfg_ok_n;
      reg_addr <= reg_addr_n;
      value    <= value_n;
      busy     <= !(state_n == ST_DONE || state_n == ST_ERROR);
      done     <= (state_n == ST_DONE);
      err      <= (state_n == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_camera_cfg_sequencer.sv
// Directed bench for camera_cfg_sequencer. Three instances, each with its
// own table: 0 = basic two-write table, 1 = delay table, 2 = 256 writes
// with no end marker. A sender model per instance latches cfg_ok when idle,
// acks one cycle later and stays busy TX cycles.
module tb_camera_cfg_sequencer;
  import camera_cfg_pkg::*;

  localparam int CLK_MS = 10;
  localparam int PWR_MS = 2;
  localparam int TX     = 16;
  localparam int ACK_TO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start, inj, mute;
  logic [2:0] ack = '0;
  logic [2:0] cfg_ok, busy, done, err;
  logic [7:0] reg_addr [3];
  logic [7:0] value [3];
  int         s_cnt [3] = '{default: 0};
  int         nwr [3]   = '{default: 0};
  logic [15:0] wlast [3] = '{default: 16'h0};
  int n_chk = 0;
  int n_fail = 0;

  function automatic cfg_rom_t tb_table(input int sel);
    cfg_rom_t t;
    for (int i = 0; i < 256; i++) t[i] = CFG_END_WORD;
    case (sel)
      0: begin t[0] = 16'h1280; t[1] = 16'h3A04; end
      1: begin
        t[0] = 16'h1280; t[1] = 16'hFF05; t[2] = 16'h1101;
        t[3] = 16'hFF00; t[4] = 16'h3A04;
      end
      default: for (int i = 0; i < 256; i++) t[i] = {1'b0, i[7:1], i[7:0]};
    endcase
    return t;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    camera_cfg_sequencer #(
      .CLK_PER_MS(CLK_MS), .POWERUP_MS(PWR_MS), .TX_CYCLES(TX),
      .ACK_TIMEOUT(ACK_TO), .MAX_ENTRIES(256), .ROM_FILE(tb_table(g))
    ) u_dut (
      .clk(clk), .reset(rst[g]), .start(start[g]), .sccb_ok(ack[g] | inj[g]),
      .cfg_ok(cfg_ok[g]), .reg_addr(reg_addr[g]), .value(value[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g])
    );
  end

  // Sender model: samples cfg_ok only while idle.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      ack[g] <= 1'b0;
      if (s_cnt[g] != 0) begin
        s_cnt[g] <= s_cnt[g] - 1;
      end else if (cfg_ok[g] && !mute[g]) begin
        s_cnt[g] <= TX;
        ack[g]   <= 1'b1;
        nwr[g]   <= nwr[g] + 1;
        wlast[g] <= {reg_addr[g], value[g]};
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_chk++;
    if ({cfg_ok[0], reg_addr[0], value[0]} !== 17'h0) begin
      n_fail++; $display("FAIL reset_req: got %h want %h", {cfg_ok[0], reg_addr[0], value[0]}, 17'h0);
    end
    n_chk++;
    if ({busy[0], done[0], err[0]} !== 3'b100) begin
      n_fail++; $display("FAIL reset_status: got %b want %b", {busy[0], done[0], err[0]}, 3'b100);
    end
  endtask

  // Edge e counts posedges with reset low. PWRUP 20, FETCH 21, DECODE 22.
  // Ack sampled at 24 -> next request at 26; sender idle again at 40, ack 41;
  // FETCH 42, DECODE->DRAIN 43, DRAIN 44..59 -> done at 59.
  // A stray sccb_ok (e5) and a start while busy (e10) must change nothing.
  task automatic test_basic();
    rst[0] = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      inj[0] = (e == 5); start[0] = (e == 10);
      step();
      case (e)
        21: begin n_chk++; if ({cfg_ok[0], busy[0]} !== 2'b01) begin n_fail++;
              $display("FAIL basic_pre_req: got %b want %b", {cfg_ok[0], busy[0]}, 2'b01); end end
        22, 23: begin n_chk++; if ({cfg_ok[0], reg_addr[0], value[0]} !== {1'b1, 16'h1280}) begin n_fail++;
              $display("FAIL basic_req1 e%0d: got %h want %h", e, {cfg_ok[0], reg_addr[0], value[0]}, {1'b1, 16'h1280}); end end
        24, 25: begin n_chk++; if (cfg_ok[0] !== 1'b0) begin n_fail++;
              $display("FAIL basic_drop e%0d: got %b want 0", e, cfg_ok[0]); end end
        26, 40: begin n_chk++; if ({cfg_ok[0], reg_addr[0], value[0]} !== {1'b1, 16'h3A04}) begin n_fail++;
              $display("FAIL basic_req2 e%0d: got %h want %h", e, {cfg_ok[0], reg_addr[0], value[0]}, {1'b1, 16'h3A04}); end end
        41: begin n_chk++; if (cfg_ok[0] !== 1'b0 || nwr[0] != 2 || wlast[0] !== 16'h3A04) begin n_fail++;
              $display("FAIL basic_writes: got cfg_ok=%b n=%0d last=%h want 0 2 3a04", cfg_ok[0], nwr[0], wlast[0]); end end
        58: begin n_chk++; if ({done[0], busy[0]} !== 2'b01) begin n_fail++;
              $display("FAIL basic_pre_done: got %b want %b", {done[0], busy[0]}, 2'b01); end end
        59: begin n_chk++; if ({done[0], busy[0], err[0]} !== 3'b100) begin n_fail++;
              $display("FAIL basic_done: got %b want %b", {done[0], busy[0], err[0]}, 3'b100); end end
        default: ;
      endcase
    end
  endtask

  // Start in DONE sampled at r1: FETCH, DECODE, request at r3, latched r4,
  // ack at r5 together with a second start (busy -> ignored), request 2 at
  // r7, sender idle r21, ack r22, DRAIN r25..r40 -> done at r40.
  task automatic test_start();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n_chk++;
    if ({done[0], busy[0]} !== 2'b01) begin n_fail++;
      $display("FAIL start_clear: got %b want %b", {done[0], busy[0]}, 2'b01); end
    for (int r = 2; r <= 40; r++) begin
      start[0] = (r == 5);
      step();
      case (r)
        3: begin n_chk++; if ({cfg_ok[0], reg_addr[0], value[0]} !== {1'b1, 16'h1280}) begin n_fail++;
             $display("FAIL start_req1: got %h want %h", {cfg_ok[0], reg_addr[0], value[0]}, {1'b1, 16'h1280}); end end
        5: begin n_chk++; if ({cfg_ok[0], busy[0]} !== 2'b01) begin n_fail++;
             $display("FAIL start_ack_same_cycle: got %b want %b", {cfg_ok[0], busy[0]}, 2'b01); end end
        7: begin n_chk++; if ({cfg_ok[0], reg_addr[0], value[0]} !== {1'b1, 16'h3A04}) begin n_fail++;
             $display("FAIL start_req2: got %h want %h", {cfg_ok[0], reg_addr[0], value[0]}, {1'b1, 16'h3A04}); end end
        39: begin n_chk++; if (done[0] !== 1'b0) begin n_fail++;
             $display("FAIL start_pre_done: got %b want 0", done[0]); end end
        40: begin n_chk++; if ({done[0], busy[0]} !== 2'b10 || nwr[0] != 4) begin n_fail++;
             $display("FAIL start_done: got %b n=%0d want 10 n=4", {done[0], busy[0]}, nwr[0]); end end
        default: ;
      endcase
    end
  endtask

  // Muted sender: ISSUE entered at 22, 40 cycles without ack -> ERROR at 62.
  task automatic test_timeout();
    mute[0] = 1'b1; rst[0] = 1'b1;
    step(); step();
    rst[0] = 1'b0;
    for (int e = 1; e <= 62; e++) begin
      step();
      if (e == 61) begin n_chk++; if ({cfg_ok[0], busy[0], err[0]} !== 3'b110) begin n_fail++;
        $display("FAIL timeout_pre: got %b want %b", {cfg_ok[0], busy[0], err[0]}, 3'b110); end end
      if (e == 62) begin n_chk++; if ({cfg_ok[0], busy[0], err[0]} !== 3'b001) begin n_fail++;
        $display("FAIL timeout_err: got %b want %b", {cfg_ok[0], busy[0], err[0]}, 3'b001); end end
    end
    mute[0] = 1'b0;
    step(); step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n_chk++;
    if ({err[0], busy[0]} !== 2'b01) begin n_fail++;
      $display("FAIL timeout_restart: got %b want %b", {err[0], busy[0]}, 2'b01); end
    step(); step();
    n_chk++;
    if ({cfg_ok[0], reg_addr[0], value[0]} !== {1'b1, 16'h1280}) begin n_fail++;
      $display("FAIL timeout_rerun_idx0: got %h want %h", {cfg_ok[0], reg_addr[0], value[0]}, {1'b1, 16'h1280}); end
  endtask

  // Reset lands on edge 41, the same edge as the ack of the second write.
  task automatic test_reset_mid();
    rst[0] = 1'b1;
    step(); step();
    rst[0] = 1'b0;
    repeat (40) step();
    rst[0] = 1'b1;
    step();
    n_chk++;
    if ({cfg_ok[0], busy[0], done[0], reg_addr[0]} !== {3'b010, 8'h00}) begin n_fail++;
      $display("FAIL reset_mid: got %h want %h", {cfg_ok[0], busy[0], done[0], reg_addr[0]}, {3'b010, 8'h00}); end
    rst[0] = 1'b0;
    for (int e = 1; e <= 23; e++) begin
      step();
      if (e == 21) begin n_chk++; if (cfg_ok[0] !== 1'b0) begin n_fail++;
        $display("FAIL reset_mid_pwrup: got %b want 0", cfg_ok[0]); end end
      if (e == 22) begin n_chk++; if ({cfg_ok[0], reg_addr[0], value[0]} !== {1'b1, 16'h1280}) begin n_fail++;
        $display("FAIL reset_mid_replay: got %h want %h", {cfg_ok[0], reg_addr[0], value[0]}, {1'b1, 16'h1280}); end end
      if (e == 23) begin n_chk++; if (wlast[0] !== 16'h1280) begin n_fail++;
        $display("FAIL reset_mid_latch: got %h want 1280", wlast[0]); end end
    end
  endtask

  // Ack at 24; DECODE of {FF,05} at 26; DELAY 27..76; request {11,01} at 78
  // (54 after the ack). {FF,00} costs 2: ack 80, request {3A,04} at 84.
  // Sender latches it at 96, ack 97, DECODE->DRAIN 99, done at 115.
  task automatic test_delay();
    rst[1] = 1'b0;
    for (int e = 1; e <= 116; e++) begin
      step();
      case (e)
        22: begin n_chk++; if ({cfg_ok[1], reg_addr[1], value[1]} !== {1'b1, 16'h1280}) begin n_fail++;
              $display("FAIL delay_req1: got %h want %h", {cfg_ok[1], reg_addr[1], value[1]}, {1'b1, 16'h1280}); end end
        50: begin n_chk++; if ({cfg_ok[1], busy[1]} !== 2'b01) begin n_fail++;
              $display("FAIL delay_mid: got %b want %b", {cfg_ok[1], busy[1]}, 2'b01); end end
        77, 83: begin n_chk++; if (cfg_ok[1] !== 1'b0) begin n_fail++;
              $display("FAIL delay_early e%0d: got %b want 0", e, cfg_ok[1]); end end
        78: begin n_chk++; if ({cfg_ok[1], reg_addr[1], value[1]} !== {1'b1, 16'h1101}) begin n_fail++;
              $display("FAIL delay_req2: got %h want %h", {cfg_ok[1], reg_addr[1], value[1]}, {1'b1, 16'h1101}); end end
        84: begin n_chk++; if ({cfg_ok[1], reg_addr[1], value[1]} !== {1'b1, 16'h3A04}) begin n_fail++;
              $display("FAIL delay_zero: got %h want %h", {cfg_ok[1], reg_addr[1], value[1]}, {1'b1, 16'h3A04}); end end
        114: begin n_chk++; if (done[1] !== 1'b0) begin n_fail++;
              $display("FAIL delay_pre_done: got %b want 0", done[1]); end end
        115: begin n_chk++; if ({done[1], busy[1]} !== 2'b10 || nwr[1] != 3) begin n_fail++;
              $display("FAIL delay_done: got %b n=%0d want 10 n=3", {done[1], busy[1]}, nwr[1]); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_no_end();
    int w;
    logic [15:0] exp_w;
    rst[2] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      exp_w = {1'b0, i[7:1], i[7:0]};
      w = 0;
      while (nwr[2] < i + 1 && w < 100) begin step(); w++; end
      n_chk++;
      if (nwr[2] != i + 1 || wlast[2] !== exp_w) begin
        n_fail++;
        $display("FAIL no_end_write%0d: got n=%0d word=%h want n=%0d word=%h", i, nwr[2], wlast[2], i + 1, exp_w);
        break;
      end
    end
    w = 0;
    while (done[2] !== 1'b1 && w < 60) begin step(); w++; end
    n_chk++;
    if (done[2] !== 1'b1) begin n_fail++;
      $display("FAIL no_end_done: got %b want 1 within 60 cycles", done[2]); end
    repeat (40) step();
    n_chk++;
    if (nwr[2] != 256 || {cfg_ok[2], busy[2]} !== 2'b00) begin n_fail++;
      $display("FAIL no_end_stop: got n=%0d cfg_ok/busy=%b want 256 00", nwr[2], {cfg_ok[2], busy[2]}); end
  endtask

  initial begin
    rst = '1; start = '0; inj = '0; mute = '0;
    test_reset();
    test_basic();
    test_start();
    test_timeout();
    test_reset_mid();
    test_delay();
    test_no_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_cfg_sequencer.md
# camera_cfg_sequencer

Walks a fixed camera initialisation table and feeds it, one register write at a time, to the SCCB sender. It sits between reset/power-up and the SCCB sender, driving the sender's `cfg_ok`, `reg_addr` and `value` inputs and consuming its `sccb_ok` accept pulse. It inserts timed delays, such as after a sensor soft reset, and reports completion or a stalled bus to the capture pipeline.

## Interface

**Parameters**
- `CLK_PER_MS`, 25000: clk cycles per millisecond (25 MHz).
- `POWERUP_MS`, 10: wait after reset before the first write. Must satisfy `POWERUP_MS*CLK_PER_MS ≥ TX_CYCLES`.
- `TX_CYCLES`, 65536: duration of one sender transfer, in clk cycles.
- `ACK_TIMEOUT`, 131072: maximum number of cycles in ISSUE without `sccb_ok`.
- `MAX_ENTRIES`, 256: table depth. The index is 8 bits.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that reruns the table. Honoured only in DONE or ERROR.
- `sccb_ok` in 1: sender accept pulse.
- `cfg_ok` out 1: write request to the sender.
- `reg_addr` out 8: register address to the sender.
- `value` out 8: register data to the sender.
- `busy` out 1: sequencing is in progress.
- `done` out 1: the table completed; level signal.
- `err` out 1: an ACK timeout occurred; level signal.

## Operation

**Table entries** are `{addr[7:0], data[7:0]}`:
- `addr≠8'hFF`: register write.
- `{8'hFF, n}` with `n` in 0..254: wait `n*CLK_PER_MS` cycles. `n=0` means no wait.
- `{8'hFF, 8'hFF}`: end of table.
- Register address 0xFF is therefore not writable.
- Reaching index `MAX_ENTRIES-1` without an end marker is treated as end of table.

**State machine** (one-hot or binary, registered outputs):
- **PWRUP**: count `POWERUP_MS*CLK_PER_MS` cycles, then go to FETCH with index=0.
- **FETCH**: register the ROM word at the current index, then go to DECODE.
- **DECODE**:
  - End marker: go to DRAIN.
  - Delay entry: go to DELAY with the counter loaded.
  - Otherwise: drive `reg_addr`/`value`, set `cfg_ok=1`, go to ISSUE.
- **ISSUE**:
  - Hold `cfg_ok`, `reg_addr` and `value` stable.
  - On `sccb_ok=1`: clear `cfg_ok`, increment the index, go to FETCH.
  - If the timeout counter reaches `ACK_TIMEOUT`: clear `cfg_ok`, go to ERROR.
- **DELAY**: count down, then increment the index and go to FETCH.
- **DRAIN**: wait `TX_CYCLES` so the final transfer completes, then go to DONE.
- **DONE**: `done=1`, `busy=0`. A `start` pulse clears `done`, sets index=0 and goes to FETCH.
- **ERROR**: `err=1`, `busy=0`. On `start`, behaves the same as DONE.

**Sender handshake:**
- The sender samples `cfg_ok` only while idle.
- `sccb_ok` arrives the cycle after the sender latched the data. Dropping `cfg_ok` on that edge is therefore safe.
- The next request may be raised while the sender is still busy; the sender accepts it when it returns to idle.

## Timing

**Reset values:**
- `cfg_ok=0`, `reg_addr=0`, `value=0`, `done=0`, `err=0`, `busy=1`.
- State is PWRUP, index=0, all counters 0.

**Latencies:**
- First `cfg_ok` rises `POWERUP_MS*CLK_PER_MS+2` cycles after `reset` deasserts.
- Between a `sccb_ok` edge and the next `cfg_ok` rise: 2 cycles (FETCH, DECODE).
- Delay entry `n`: `n*CLK_PER_MS` cycles spent in DELAY, plus 2 cycles of overhead.

**Boundary and corner cases:**
- `sccb_ok` outside ISSUE: ignored.
- `start` while busy: ignored.
- `start` and `sccb_ok` in the same cycle: `start` is ignored because the block is busy.
- Reset mid-transfer: outputs drop on the same edge and the block restarts in PWRUP. The PWRUP wait covers the sender's in-flight transfer, so the two never overlap.
- Timeout counter clears on every entry to ISSUE.
- Index increment saturates at `MAX_ENTRIES-1`.

## Structure

**Shared package** `camera_cfg_pkg` holds:
- The state enum.
- `CFG_DELAY_ADDR=8'hFF` and `CFG_END_WORD=16'hFFFF`.
- The default timing constants.

**Sub-module** `camera_cfg_rom`:
- Combinational lookup, `index[7:0] -> word[15:0]`.
- Parameter `ROM_FILE`; benches substitute their own table through it.
- Production table starts with `{12,80}`, `{FF,0A}`, then the sensor register list, then `{FF,FF}`.

## Test plan

Benches use `CLK_PER_MS=10`, `POWERUP_MS=2`, `TX_CYCLES=16` and a sender model that acks 1 cycle after an idle sample.

1. **Basic write sequence.** Table `{12,80}`, `{3A,04}`, `{FF,FF}`.
   - Two writes appear in order, with `cfg_ok` first high at cycle 22.
   - `done=1` arrives `TX_CYCLES` after the second ack; `busy=0`.
2. **Delay entry.** Table `{12,80}`, `{FF,05}`, `{11,01}`, `{FF,FF}`.
   - Gap between the first ack and the second `cfg_ok` = 50+4 cycles.
   - `{FF,00}` adds only 2 cycles.
3. **Missing ack.** Model never asserts `sccb_ok`.
   - After `ACK_TIMEOUT` cycles: `err=1`, `cfg_ok=0`, `busy=0`.
   - A `start` pulse reruns the table from index 0 and clears `err`.
4. **Reset mid-sequence.** Assert `reset` during the second ISSUE.
   - Next cycle: `cfg_ok=0`, `busy=1`, `done=0`.
   - The sequence replays from `{12,80}`.
5. **Start handling.**
   - `start` pulsed while busy: no effect.
   - `start` pulsed in DONE: identical write sequence repeated, `done` low until it completes.
6. **No end marker.** Table of 256 writes with no end marker: all 256 are issued once, then DRAIN and `done=1`.
